instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 4, instruction buffer entries (power of two, 2..16).
REQ-003 Parameter MAX_OUTSTANDING, default 2, granted-but-unanswered memory requests (1..FIFO_DEPTH).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 imem_req  output  1  fetch request valid.
REQ-007 imem_addr  output  32  fetch word address; bits [1:0] always 0.
REQ-008 imem_gnt  input  1  request accepted this cycle (only meaningful when imem_req=1).
REQ-009 imem_rvalid  input  1  response valid; exactly one per grant, in grant order, at least 1 cycle after grant.
REQ-010 imem_rdata  input  32  instruction word for the response.
REQ-011 redirect  input  1  flow-control redirect (branch/jump taken).
REQ-012 redirect_pc  input  32  new fetch target.
REQ-013 instr_valid  output  1  instr/instr_pc valid toward the decoder.
REQ-014 instr  output  32  instruction word.
REQ-015 instr_pc  output  32  address of instr.
REQ-016 instr_ready  input  1  decoder accepts instr; transfer when instr_valid && instr_ready.
REQ-017 fetch_fault  output  1  misaligned-redirect fault, sticky.

Function
REQ-018 States: RUN (fetching), FAULT (halted); reset enters RUN.
REQ-019 In RUN, imem_req=1 iff fifo_count + live_outstanding < FIFO_DEPTH and total_outstanding < MAX_OUTSTANDING.
REQ-020 imem_addr=fetch_pc; on imem_req && imem_gnt, fetch_pc += 4 (wraps modulo 2^32) and outstanding counter increments.
REQ-021 While imem_req=1 and imem_gnt=0, imem_addr stays stable unless redirect is asserted.
REQ-022 Response with drop_count=0: {resp_pc, imem_rdata} pushed into FIFO, resp_pc += 4; visible on instr_valid the next cycle (1-cycle registered latency).
REQ-023 Response with drop_count>0: discarded, drop_count decrements, no push.
REQ-024 FIFO never overflows; space is reserved per REQ-019, so a non-dropped response always finds space.
REQ-025 Output is the FIFO head; pop on instr_valid && instr_ready; simultaneous push and pop allowed when full or empty.
REQ-026 Redirect with redirect_pc[1:0]==0: next cycle FIFO empty, fetch_pc=resp_pc=redirect_pc, drop_count=all outstanding including a grant and excluding a response in the redirect cycle; imem_req may assert that same next cycle.
REQ-027 Redirect overrides a same-cycle pop and a same-cycle push (both discarded).
REQ-028 Redirect with redirect_pc[1:0]!=0: enter FAULT; fetch_fault=1; FIFO flushed; imem_req=0; in-flight responses still counted and dropped.
REQ-029 In FAULT, an aligned redirect returns to RUN per REQ-026 and clears fetch_fault; a misaligned redirect keeps FAULT.
REQ-030 instr_valid=0 whenever the FIFO is empty; instr/instr_pc are don't-care then.

Reset
REQ-031 While reset=1: imem_req=0, instr_valid=0, fetch_fault=0, FIFO empty, outstanding=0, drop_count=0, fetch_pc=resp_pc=RESET_PC, state RUN.
REQ-032 First cycle after reset deasserts: imem_req=1, imem_addr=RESET_PC.
REQ-033 Reset mid-operation discards all FIFO contents and forgets outstanding requests; the memory system is reset together with this block.

Verification
REQ-034 Reset release, gnt always 1, rvalid 1 cycle after gnt, ready=1 -> instr_pc 0x0,0x4,0x8,... back-to-back, first instr_valid 3 cycles after reset release.
REQ-035 ready=0 held -> exactly FIFO_DEPTH(4) entries buffered, imem_req drops to 0, no data loss; ready=1 -> in-order drain from PC 0x0.
REQ-036 Two requests outstanding, redirect to 0x100 -> both stale responses dropped, next instr_pc=0x100 with data from address 0x100.
REQ-037 Redirect to 0x102 -> fetch_fault=1, imem_req=0, instr_valid=0; then redirect to 0x200 -> fault cleared, instr_pc=0x200 delivered.
REQ-038 Redirect coincident with pop and rvalid -> popped/pushed entries discarded, no duplicate or stale instr_pc observed.
REQ-039 gnt withheld 5 cycles -> imem_addr stable for all 5 cycles; fetch_pc 0xFFFF_FFFC granted -> next imem_addr 0x0000_0000.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues word fetches, buffers responses in a FIFO,
// handles redirects by flushing and dropping stale in-flight responses.
module instr_fetch #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        fetch_fault
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic {
        ST_RUN,
        ST_FAULT
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [31:0]       resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [31:0]       fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]       fifo_data_q [FIFO_DEPTH];

    logic [CNT_W-1:0]  live;
    logic [CNT_W:0]    reserved;
    logic              req;
    logic              grant;
    logic              aligned;
    logic              vld;
    logic              push;
    logic              pop;

    always_comb begin
        // Space is reserved for every request that will actually be pushed.
        live     = outst_q - drop_q;
        reserved = {1'b0, cnt_q} + {1'b0, live};
        req      = !reset && (state_q == ST_RUN) &&
                   (reserved < DEPTH_C) && (outst_q < MAX_C);
        grant    = req && imem_gnt;
        aligned  = (redirect_pc[1:0] == 2'b00);
        vld      = !reset && (cnt_q != '0);
        push     = imem_rvalid && (drop_q == '0) && !redirect;
        pop      = vld && instr_ready && !redirect;

        outst_d  = outst_q + CNT_W'(grant) - CNT_W'(imem_rvalid);

        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        drop_d     = drop_q;
        cnt_d      = cnt_q + CNT_W'(push) - CNT_W'(pop);
        wptr_d     = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d     = pop ? rptr_q + 1'b1 : rptr_q;

        if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
        if (push) resp_pc_d = resp_pc_q + 32'd4;
        if (imem_rvalid && (drop_q != '0)) drop_d = drop_q - 1'b1;

        if (redirect) begin
            // Everything still in flight after this edge belongs to the old path.
            drop_d = outst_d;
            cnt_d  = '0;
            wptr_d = '0;
            rptr_d = '0;
            if (aligned) begin
                state_d    = ST_RUN;
                fetch_pc_d = redirect_pc;
                resp_pc_d  = redirect_pc;
            end else begin
                state_d = ST_FAULT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wptr_q]   <= resp_pc_q;
            fifo_data_q[wptr_q] <= imem_rdata;
        end
    end

    assign imem_req    = req;
    assign imem_addr   = {fetch_pc_q[31:2], 2'b00};
    assign instr_valid = vld;
    assign instr       = fifo_data_q[rptr_q];
    assign instr_pc    = fifo_pc_q[rptr_q];
    assign fetch_fault = !reset && (state_q == ST_FAULT);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a small in-order memory model
// answering each grant one cycle later (data = addr ^ 32'hDEAD_BEEF).
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        fetch_fault;

    logic        hold;
    logic [31:0] pend_q[$];
    int          vec_cnt = 0;
    int          err_cnt = 0;

    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_PC       (32'h0000_0000),
        .FIFO_DEPTH     (4),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_ready(instr_ready),
        .fetch_fault(fetch_fault)
    );

    always @(posedge clk) begin
        if (reset) begin
            pend_q.delete();
        end else begin
            if (imem_rvalid) void'(pend_q.pop_front());
            if (imem_req && imem_gnt) pend_q.push_back(imem_addr);
        end
        #1;
        if (!hold && pend_q.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend_q[0] ^ 32'hDEAD_BEEF;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (instr_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(instr_valid), 32'h1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_fault", 32'(fetch_fault), 32'h0);
        reset = 1'b0;
        #1;
        chk("rel_req", 32'(imem_req), 32'h1);
        chk("rel_addr", imem_addr, 32'h0000_0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b1;
        hold        = 1'b0;

        // Streaming after reset
        do_reset();
        @(negedge clk);
        chk("s_valid_n1", 32'(instr_valid), 32'h0);
        @(negedge clk);
        chk("s_valid_n2", 32'(instr_valid), 32'h1);
        chk("s_pc0", instr_pc, 32'h0000_0000);
        chk("s_data0", instr, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("s_pc4", instr_pc, 32'h0000_0004);
        @(negedge clk);
        chk("s_pc8", instr_pc, 32'h0000_0008);
        chk("s_data8", instr, 32'hDEAD_BEE7);

        // Backpressure fills the buffer, then in-order drain
        instr_ready = 1'b0;
        do_reset();
        repeat (10) @(negedge clk);
        chk("bp_req", 32'(imem_req), 32'h0);
        chk("bp_valid", 32'(instr_valid), 32'h1);
        chk("bp_head", instr_pc, 32'h0000_0000);
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("bp_drain_pc", instr_pc, 32'(4 * i));
            chk("bp_drain_v", 32'(instr_valid), 32'h1);
            @(negedge clk);
        end

        // Redirect with two requests outstanding
        hold = 1'b1;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        chk("r2_req_sat", 32'(imem_req), 32'h0);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        hold        = 1'b0;
        @(negedge clk);
        redirect = 1'b0;
        chk("r2_valid0", 32'(instr_valid), 32'h0);
        chk("r2_addr", imem_addr, 32'h0000_0100);
        wait_valid("r2_wait");
        chk("r2_pc", instr_pc, 32'h0000_0100);
        chk("r2_data", instr, 32'hDEAD_BFEF);
        @(negedge clk);
        chk("r2_pc_next", instr_pc, 32'h0000_0104);

        // Misaligned redirect faults, aligned one recovers
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        @(negedge clk);
        redirect = 1'b0;
        chk("f_fault", 32'(fetch_fault), 32'h1);
        chk("f_req", 32'(imem_req), 32'h0);
        chk("f_valid", 32'(instr_valid), 32'h0);
        repeat (3) @(negedge clk);
        chk("f_fault_hold", 32'(fetch_fault), 32'h1);
        chk("f_valid_hold", 32'(instr_valid), 32'h0);
        chk("f_req_hold", 32'(imem_req), 32'h0);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0106;
        @(negedge clk);
        redirect = 1'b0;
        chk("f_fault_mis2", 32'(fetch_fault), 32'h1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(negedge clk);
        redirect = 1'b0;
        chk("f_cleared", 32'(fetch_fault), 32'h0);
        wait_valid("f_wait");
        chk("f_pc", instr_pc, 32'h0000_0200);
        chk("f_data", instr, 32'hDEAD_BCEF);
        @(negedge clk);
        chk("f_pc_next", instr_pc, 32'h0000_0204);

        // Redirect coincident with a pop and a response
        chk("c_pre_valid", 32'(instr_valid), 32'h1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        @(negedge clk);
        redirect = 1'b0;
        chk("c_flushed", 32'(instr_valid), 32'h0);
        wait_valid("c_wait");
        chk("c_pc0", instr_pc, 32'h0000_0300);
        @(negedge clk);
        chk("c_pc1", instr_pc, 32'h0000_0304);
        @(negedge clk);
        chk("c_pc2", instr_pc, 32'h0000_0308);

        // Grant withheld, then address wrap
        imem_gnt = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            chk("g_req", 32'(imem_req), 32'h1);
            chk("g_addr", imem_addr, 32'h0000_0000);
            @(negedge clk);
        end
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0;
        chk("w_addr", imem_addr, 32'hFFFF_FFFC);
        chk("w_req", 32'(imem_req), 32'h1);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        chk("w_wrap", imem_addr, 32'h0000_0000);
        imem_gnt = 1'b1;
        wait_valid("w_wait");
        chk("w_pc", instr_pc, 32'hFFFF_FFFC);
        chk("w_data", instr, 32'h2152_4113);
        @(negedge clk);
        chk("w_pc_next", instr_pc, 32'h0000_0000);
        chk("w_data_next", instr, 32'hDEAD_BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
